// File: rtl/sdm_dac_pkg.sv
// Shared definitions for the sigma-delta DAC interpolation path.
// Holds the CIC width helper, a clog2 helper and the stage-count ceiling.
package sdm_dac_pkg;

  // Largest comb/integrator stage count the CIC interpolator supports.
  localparam int CIC_MAX_N = 6;

  // Ceiling log2 for sizing counters and indices.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 32'sd0;
    v   = value - 32'sd1;
    while (v > 32'sd0) begin
      res = res + 32'sd1;
      v   = v >>> 1;
    end
    return res;
  endfunction

  // Full-precision internal width of an N-stage CIC interpolator.
  // The zero-stuffed integrator chain has gain R^(N-1), so this many bits
  // carry the DC-steady result exactly.
  function automatic int cic_width(input int in_w, input int n, input int log2r);
    return in_w + (n - 32'sd1) * log2r;
  endfunction

endpackage

// File: rtl/cic_interp_param_int_stage.sv
// One integrator of the CIC interpolator: a W-bit enabled accumulator.
// Wrap-around modulo 2^W is the intended arithmetic; it never saturates.
module cic_int_stage
  import sdm_dac_pkg::*;
#(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  // Next accumulator value: add the input on enable, otherwise hold.
  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = acc_q + din;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= {W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/cic_interp_param.sv
// Parametrised N-stage CIC interpolator, ratio R = 2^LOG2R, differential
// delay 1. Generates its own input-rate strobe (ce_out) from clk_enable so
// stages can be chained ce_out -> clk_enable. Output is MSB-aligned.
// Optional build macro: CIC_ROUND_EN selects round-half-up with positive
// saturation on the output instead of plain truncation.
module cic_interp_param
  import sdm_dac_pkg::*;
#(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16,
  parameter int N     = 3,
  parameter int LOG2R = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic [IN_W-1:0]  input_data,
  output logic [OUT_W-1:0] output_data,
  output logic             ce_out
);

  localparam int W  = cic_width(IN_W, N, LOG2R);
  localparam int SH = W - OUT_W;

  logic [LOG2R-1:0] phase_q;
  logic [LOG2R-1:0] phase_d;
  logic [W-1:0]     in_q;
  logic [W-1:0]     in_d;
  logic [W-1:0]     z_q;
  logic [W-1:0]     z_d;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] out_d;
  logic             ce_s;
  logic [W-1:0]     y_n_s;
  logic [W-1:0]     i_n_s;
  logic [OUT_W-1:0] out_s;

  // Input-rate strobe: first output slot of every R-cycle frame, never in reset.
  assign ce_s   = clk_enable & reset & (phase_q == {LOG2R{1'b0}});
  assign ce_out = ce_s;

  // Comb section at input rate; chain is purely combinational from in_q.
  for (genvar k = 0; k < N; k++) begin : g_comb
    logic [W-1:0] x_s;
    logic [W-1:0] y_s;
    logic [W-1:0] dly_q;
    logic [W-1:0] dly_d;

    if (k == 0) begin : g_src
      assign x_s = in_q;
    end else begin : g_src
      assign x_s = g_comb[k-1].y_s;
    end

    assign y_s = x_s - dly_q;

    // Differential delay loads the stage input once per input sample.
    always_comb begin
      dly_d = dly_q;
      if (ce_s) begin
        dly_d = x_s;
      end else begin
        dly_d = dly_q;
      end
    end

    // Comb delay register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dly_q <= {W{1'b0}};
      end else begin
        dly_q <= dly_d;
      end
    end
  end

  assign y_n_s = g_comb[N-1].y_s;

  // Integrator chain at output rate; the first stage eats the zero-stuffed stream.
  for (genvar k = 0; k < N; k++) begin : g_int
    logic [W-1:0] din_s;
    logic [W-1:0] acc_s;

    if (k == 0) begin : g_src
      assign din_s = z_q;
    end else begin : g_src
      assign din_s = g_int[k-1].acc_s;
    end

    cic_int_stage #(
      .W (W)
    ) u_stage (
      .clk   (clk),
      .rst_n (reset),
      .en    (clk_enable),
      .din   (din_s),
      .acc   (acc_s)
    );
  end

  assign i_n_s = g_int[N-1].acc_s;

`ifdef CIC_ROUND_EN
  if (SH > 0) begin : g_round
    localparam logic [W:0]       HALF    = (W + 1)'(1'b1) << (SH - 1);
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    logic [W:0] sum_s;

    assign sum_s = {i_n_s[W-1], i_n_s} + HALF;

    // Round half up; the positive offset can only overflow toward +max.
    always_comb begin
      out_s = sum_s[W-1 -: OUT_W];
      if (!sum_s[W] && sum_s[W-1]) begin
        out_s = OUT_MAX;
      end else begin
        out_s = sum_s[W-1 -: OUT_W];
      end
    end
  end else begin : g_trunc
    assign out_s = i_n_s[W-1 -: OUT_W];
  end
`else
  assign out_s = i_n_s[W-1 -: OUT_W];
`endif

  // Next-state for phase, input capture, zero-stuff slot and output.
  always_comb begin
    phase_d = phase_q;
    in_d    = in_q;
    z_d     = z_q;
    out_d   = out_q;
    if (clk_enable) begin
      phase_d = phase_q + LOG2R'(1'b1);
      z_d     = (phase_q == LOG2R'(1'b1)) ? y_n_s : {W{1'b0}};
      out_d   = out_s;
    end else begin
      phase_d = phase_q;
      z_d     = z_q;
      out_d   = out_q;
    end
    if (ce_s) begin
      in_d = W'($signed(input_data));
    end else begin
      in_d = in_q;
    end
  end

  // Control and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= {LOG2R{1'b0}};
      in_q    <= {W{1'b0}};
      z_q     <= {W{1'b0}};
      out_q   <= {OUT_W{1'b0}};
    end else begin
      phase_q <= phase_d;
      in_q    <= in_d;
      z_q     <= z_d;
      out_q   <= out_d;
    end
  end

  assign output_data = out_q;

endmodule
